// File: rtl/riscv_pkg.sv
// Shared core-wide constants for the RV32 front end.
//   XLEN      : architectural register / PC width
//   NOP_INSTR : canonical NOP (addi x0, x0, 0) shown when no instruction is available
//   PC_STEP   : byte increment between sequential instruction words
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

  // Forces an address onto a word boundary.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered storage array and a clear input.
//   clk_i    : clock
//   reset_i  : synchronous active-high reset (empties the FIFO)
//   clear_i  : empties the FIFO; wins over push_i / pop_i in the same cycle
//   push_i   : write wdata_i (ignored when full unless a pop happens in the same cycle)
//   wdata_i  : write data
//   pop_i    : drop the head entry (ignored when empty)
//   rdata_o  : head entry (undefined when empty)
//   full_o   : DEPTH entries held
//   empty_o  : no entries held
//   count_o  : number of entries held
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_eff, pop_eff;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
  endfunction

  always_comb begin
    empty_o  = (count_q == '0);
    full_o   = (count_q == CntW'(DEPTH));
    pop_eff  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot being written.
    push_eff = push_i && (!full_o || pop_eff);
    rdata_o  = mem_q[rd_ptr_q];
    count_o  = count_q;

    wr_ptr_d = push_eff ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_eff  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_eff && !pop_eff) begin
      count_d = count_q + CntW'(1);
    end else if (pop_eff && !push_eff) begin
      count_d = count_q - CntW'(1);
    end

    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && !clear_i && push_eff) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch queue between the instruction-memory port and IF/ID.
// Issues sequential word fetches, tags returning words with their PCs and hands
// them to decode one per cycle under valid/ready. A redirect flushes the queue and
// restarts fetching; responses still in flight at that point are dropped on return.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   iaddr_o, ird_o        : fetch address (word aligned) and request
//   igrant_i              : memory accepts the request this cycle
//   irvalid_i, irdata_i   : in-order response valid and instruction word
//   redirect_i            : flush and refetch from redirect_pc_i
//   redirect_pc_i         : new fetch PC
//   inst_valid_o          : head entry valid
//   inst_ready_i          : decode accepts the head
//   inst_o, inst_pc_o     : head instruction and its PC (NOP / 0 when empty)
module ifetch_queue
  import riscv_pkg::*;
#(
  parameter int unsigned     DEPTH           = 4,
  parameter int unsigned     MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            reset_i,
  output logic [XLEN-1:0] iaddr_o,
  output logic            ird_o,
  input  logic            igrant_i,
  input  logic            irvalid_i,
  input  logic [XLEN-1:0] irdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned OutW = $clog2(MAX_OUTSTANDING + 1);

  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [OutW-1:0]   outstanding_q, outstanding_d;
  logic [OutW-1:0]   discard_q, discard_d;

  logic              grant;
  logic              resp_keep;
  logic              pop_inst;
  logic              credit_ok;

  logic [2*XLEN-1:0] q_rdata;
  logic              q_full, q_empty;
  logic [CntW-1:0]   q_count;

  logic [XLEN-1:0]   pc_head;
  logic              pc_full, pc_empty;
  logic [OutW-1:0]   pc_count;
  logic              pc_track_ok;

  always_comb begin
    // Live (non-discarded) requests plus held entries must fit in the queue, so
    // every response that is kept always has a slot waiting for it.
    credit_ok = (int'(outstanding_q) - int'(discard_q) + int'(q_count)) < int'(DEPTH);
    ird_o     = !reset_i && !redirect_i && credit_ok &&
                (outstanding_q < OutW'(MAX_OUTSTANDING));
    grant     = ird_o && igrant_i;
    iaddr_o   = fetch_pc_q;

    resp_keep = irvalid_i && !redirect_i && (discard_q == '0);
    pop_inst  = inst_valid_o && inst_ready_i && !redirect_i;

    outstanding_d = outstanding_q;
    if (grant) begin
      outstanding_d = outstanding_d + OutW'(1);
    end
    if (irvalid_i) begin
      outstanding_d = outstanding_d - OutW'(1);
    end

    fetch_pc_d = grant ? fetch_pc_q + PC_STEP : fetch_pc_q;
    discard_d  = discard_q;
    if (redirect_i) begin
      fetch_pc_d = word_align(redirect_pc_i);
      // No grant on a redirect cycle, so everything still in flight afterwards
      // belongs to the old stream.
      discard_d  = outstanding_d;
    end else if (irvalid_i && (discard_q != '0)) begin
      discard_d  = discard_q - OutW'(1);
    end

    inst_valid_o = !q_empty;
    inst_o       = q_empty ? NOP_INSTR : q_rdata[XLEN-1:0];
    inst_pc_o    = q_empty ? '0 : q_rdata[2*XLEN-1:XLEN];

    // Entries in the PC FIFO always mirror live in-flight requests.
    pc_track_ok = (int'(pc_count) == int'(outstanding_q) - int'(discard_q));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  // PC of every live request, in issue order; discarded responses never touch it.
  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pc_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (redirect_i),
    .push_i  (grant),
    .wdata_i (fetch_pc_q),
    .pop_i   (resp_keep),
    .rdata_o (pc_head),
    .full_o  (pc_full),
    .empty_o (pc_empty),
    .count_o (pc_count)
  );

  sync_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (redirect_i),
    .push_i  (resp_keep),
    .wdata_i ({pc_head, irdata_i}),
    .pop_i   (pop_inst),
    .rdata_o (q_rdata),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  a_inst_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(resp_keep && q_full && !pop_inst));
  a_pc_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(grant && pc_full));
  a_pc_known: assert property (@(posedge clk_i) disable iff (reset_i)
    !(resp_keep && pc_empty));
  a_pc_tracking: assert property (@(posedge clk_i) disable iff (reset_i) pc_track_ok);

endmodule
